// File: rtl/halfwave_analyzer_if.sv
// Sample-stream and measurement signals of halfwave_analyzer.
// master drives the rectified half-wave samples; slave returns the sample and measurement results.
interface halfwave_analyzer_if #(
   parameter int PERIOD_W = 16
) ();
   logic                smp_valid;
   logic [7:0]          pos_in;
   logic [7:0]          neg_in;
   logic signed [8:0]   sample_out;
   logic [PERIOD_W-1:0] period_out;
   logic [7:0]          peak_out;
   logic                meas_valid;
   logic                proto_err;
   logic                ovf;

   modport master (
      output smp_valid, pos_in, neg_in,
      input  sample_out, period_out, peak_out, meas_valid, proto_err, ovf
   );

   modport slave (
      input  smp_valid, pos_in, neg_in,
      output sample_out, period_out, peak_out, meas_valid, proto_err, ovf
   );
endinterface

// File: rtl/halfwave_analyzer.sv
// Recombines rectified half-waves into signed samples and measures samples-per-cycle; all outputs 1 clk after the sample.
// Peak-magnitude tracking is built only when HALFWAVE_ANALYZER_PEAK_EN is defined; otherwise peak_out is tied to 0.
module halfwave_analyzer #(
   parameter int PERIOD_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   halfwave_analyzer_if.slave bus
);
   typedef enum logic [1:0] {SYNC, ARM, POS_HALF, NEG_HALF} state_e;
   typedef enum logic [1:0] {CLS_ZERO, CLS_POS, CLS_NEG, CLS_BAD} cls_e;

   localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
   localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

   state_e              state_q;
   cls_e                cls;
   logic [PERIOD_W-1:0] count_q, count_d;
   logic [PERIOD_W-1:0] period_q;
   logic signed [8:0]   sample_q, sample_d;
   logic                meas_q, perr_q, ovf_q;
   logic                rising, meas_due, cnt_due, cnt_sat;

   always_comb begin
      case ({|bus.pos_in, |bus.neg_in})
         2'b00:   cls = CLS_ZERO;
         2'b10:   cls = CLS_POS;
         2'b01:   cls = CLS_NEG;
         default: cls = CLS_BAD;
      endcase
      sample_d = $signed({1'b0, bus.pos_in}) - $signed({1'b0, bus.neg_in});
      // A rising transition restarts the count; every other sample inside a half counts, BAD included.
      rising   = bus.smp_valid && (cls == CLS_POS) && ((state_q == ARM) || (state_q == NEG_HALF));
      meas_due = rising && (state_q == NEG_HALF);
      cnt_due  = bus.smp_valid && !rising && ((state_q == POS_HALF) || (state_q == NEG_HALF));
      cnt_sat  = cnt_due && (count_q == CNT_MAX);
      count_d  = count_q;
      if (rising) begin
         count_d = CNT_ONE;
      end else if (cnt_sat) begin
         count_d = '0;
      end else if (cnt_due) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= SYNC;
         count_q  <= '0;
         period_q <= '0;
         sample_q <= '0;
         meas_q   <= 1'b0;
         perr_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         meas_q  <= 1'b0;
         perr_q  <= 1'b0;
         ovf_q   <= 1'b0;
         count_q <= count_d;
         if (bus.smp_valid) begin
            if (cls == CLS_BAD) begin
               perr_q <= 1'b1;
            end else begin
               sample_q <= sample_d;
            end
            if (meas_due) begin
               period_q <= count_q;
               meas_q   <= 1'b1;
            end
            if (cnt_sat) begin
               ovf_q   <= 1'b1;
               state_q <= SYNC;
            end else begin
               case (state_q)
                  SYNC:          if (cls == CLS_NEG) state_q <= ARM;
                  ARM, NEG_HALF: if (cls == CLS_POS) state_q <= POS_HALF;
                  POS_HALF:      if (cls == CLS_NEG) state_q <= NEG_HALF;
                  default:       state_q <= SYNC;
               endcase
            end
         end
      end
   end

`ifdef HALFWAVE_ANALYZER_PEAK_EN
   logic [7:0] peak_run_q, peak_out_q, mag;

   assign mag = (bus.pos_in > bus.neg_in) ? bus.pos_in : bus.neg_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         peak_run_q <= '0;
         peak_out_q <= '0;
      end else if (bus.smp_valid) begin
         if (cnt_sat) begin
            peak_run_q <= '0;
         end else if (rising) begin
            if (meas_due) begin
               peak_out_q <= peak_run_q;
            end
            peak_run_q <= bus.pos_in;
         end else if (cnt_due && (cls != CLS_BAD) && (mag > peak_run_q)) begin
            peak_run_q <= mag;
         end
      end
   end

   assign bus.peak_out = peak_out_q;
`else
   assign bus.peak_out = '0;
`endif

   assign bus.sample_out = sample_q;
   assign bus.period_out = period_q;
   assign bus.meas_valid = meas_q;
   assign bus.proto_err  = perr_q;
   assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_halfwave_analyzer.sv
// Drives a 16-bit and an 8-bit period instance with identical sample streams and checks both every clk
// against a sign-history reference model.
module tb_halfwave_analyzer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   halfwave_analyzer_if #(.PERIOD_W(16)) bus16 ();
   halfwave_analyzer_if #(.PERIOD_W(8))  bus8 ();

   halfwave_analyzer #(.PERIOD_W(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));
   halfwave_analyzer #(.PERIOD_W(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));

`ifdef HALFWAVE_ANALYZER_PEAK_EN
   localparam bit PEAK_EN = 1'b1;
`else
   localparam bit PEAK_EN = 1'b0;
`endif

   int n_chk = 0;
   int n_bad = 0;
   int sp[256];
   int sn[256];

   // Reference state per instance: [0] is PERIOD_W=16, [1] is PERIOD_W=8.
   int cmax[2] = '{65535, 255};
   int m_sample[2], m_period[2], m_peak[2], m_meas[2], m_perr[2], m_ovf[2];
   int last_sign[2], started[2], vcount[2], rise_idx[2], runmax[2];
   int meas_obs[2], ovf_obs[2], perr_obs[2];

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // A rise is a POS sample whose most recent signed sample since sync was NEG; the period is the
   // number of valid samples between consecutive rises.
   task automatic mdl_step(input int u, input bit rst, input bit v, input int p, input int n);
      bit is_bad, is_pos, is_neg;
      m_meas[u] = 0;
      m_perr[u] = 0;
      m_ovf[u]  = 0;
      if (rst) begin
         m_sample[u] = 0; m_period[u] = 0; m_peak[u] = 0;
         last_sign[u] = 0; started[u] = 0; vcount[u] = 0; rise_idx[u] = 0; runmax[u] = 0;
         return;
      end
      if (!v) return;
      vcount[u]++;
      is_bad = (p != 0) && (n != 0);
      is_pos = (p != 0) && (n == 0);
      is_neg = (n != 0) && (p == 0);
      if (is_bad) m_perr[u] = 1;
      else m_sample[u] = p - n;
      if (is_pos && last_sign[u] == -1) begin
         if (started[u] != 0) begin
            m_period[u] = vcount[u] - rise_idx[u];
            m_peak[u]   = runmax[u];
            m_meas[u]   = 1;
         end
         started[u]   = 1;
         rise_idx[u]  = vcount[u];
         runmax[u]    = p;
         last_sign[u] = 1;
      end else if (started[u] != 0 && (vcount[u] - rise_idx[u]) == cmax[u]) begin
         m_ovf[u]     = 1;
         started[u]   = 0;
         last_sign[u] = 0;
      end else begin
         if (started[u] != 0 && !is_bad) begin
            if (p > runmax[u]) runmax[u] = p;
            if (n > runmax[u]) runmax[u] = n;
         end
         if (is_pos) last_sign[u] = 1;
         if (is_neg) last_sign[u] = -1;
      end
   endtask

   task automatic step(input bit rst, input bit v, input int p, input int n);
      reset           = rst;
      bus16.smp_valid = v;
      bus16.pos_in    = 8'(p);
      bus16.neg_in    = 8'(n);
      bus8.smp_valid  = v;
      bus8.pos_in     = 8'(p);
      bus8.neg_in     = 8'(n);
      @(posedge clk);
      mdl_step(0, rst, v, p, n);
      mdl_step(1, rst, v, p, n);
      #1;
      chk("w16.sample", int'($signed(bus16.sample_out)), m_sample[0]);
      chk("w16.period", int'(bus16.period_out), m_period[0]);
      chk("w16.peak",   int'(bus16.peak_out), PEAK_EN ? m_peak[0] : 0);
      chk("w16.meas",   int'(bus16.meas_valid), m_meas[0]);
      chk("w16.perr",   int'(bus16.proto_err), m_perr[0]);
      chk("w16.ovf",    int'(bus16.ovf), m_ovf[0]);
      chk("w8.sample",  int'($signed(bus8.sample_out)), m_sample[1]);
      chk("w8.period",  int'(bus8.period_out), m_period[1]);
      chk("w8.peak",    int'(bus8.peak_out), PEAK_EN ? m_peak[1] : 0);
      chk("w8.meas",    int'(bus8.meas_valid), m_meas[1]);
      chk("w8.perr",    int'(bus8.proto_err), m_perr[1]);
      chk("w8.ovf",     int'(bus8.ovf), m_ovf[1]);
      if (bus16.meas_valid) meas_obs[0]++;
      if (bus8.meas_valid)  meas_obs[1]++;
      if (bus16.ovf)        ovf_obs[0]++;
      if (bus8.ovf)         ovf_obs[1]++;
      if (bus16.proto_err)  perr_obs[0]++;
   endtask

   task automatic clear_obs();
      for (int u = 0; u < 2; u++) begin
         meas_obs[u] = 0;
         ovf_obs[u]  = 0;
         perr_obs[u] = 0;
      end
   endtask

   task automatic run_sine(input int nsamp, input int gap, input int start_idx, input int bad_at,
                           output int first_meas);
      int idx, p, n;
      first_meas = -1;
      for (int s = 0; s < nsamp; s++) begin
         idx = (start_idx + s) % 256;
         p = sp[idx];
         n = sn[idx];
         if (s == bad_at) begin
            p = 5;
            n = 7;
         end
         step(1'b0, 1'b1, p, n);
         if (s == bad_at) begin
            chk("bad.perr", int'(bus16.proto_err), 1);
            chk("bad.hold", int'($signed(bus16.sample_out)), sp[(start_idx + s - 1) % 256]);
         end
         if (first_meas < 0 && bus16.meas_valid) first_meas = s;
         for (int g = 0; g < gap; g++) begin
            step(1'b0, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
         end
      end
   endtask

   initial begin
      int first, ovf_at, sign, seglen, mag, r, p, n;
      bit v, rst;

      for (int i = 0; i < 256; i++) begin
         real x;
         x = 255.0 * $sin(2.0 * 3.14159265358979 * i / 256.0);
         sp[i] = (i >= 1 && i <= 127) ? int'(x) : 0;
         sn[i] = (i >= 129) ? int'(-x) : 0;
      end

      // Reset wins over a simultaneous valid sample.
      step(1'b1, 1'b1, 200, 0);
      chk("rst.sample", int'($signed(bus16.sample_out)), 0);
      chk("rst.period", int'(bus16.period_out), 0);
      chk("rst.peak",   int'(bus16.peak_out), 0);
      chk("rst.meas",   int'(bus16.meas_valid), 0);
      chk("rst.perr",   int'(bus16.proto_err), 0);
      chk("rst.ovf",    int'(bus16.ovf), 0);
      step(1'b1, 1'b0, 0, 0);

      clear_obs();
      run_sine(4 * 256 + 2, 0, 0, -1, first);
      chk("sine.first_meas", first, 513);
      chk("sine.meas_cnt", meas_obs[0], 3);
      chk("sine.period", int'(bus16.period_out), 256);
      chk("sine.peak", int'(bus16.peak_out), PEAK_EN ? 255 : 0);
      chk("sine.w8_meas", meas_obs[1], 0);
      chk("sine.w8_ovf", ovf_obs[1], 2);

      step(1'b1, 1'b0, 0, 0);
      clear_obs();
      run_sine(3 * 256 + 2, 2, 0, -1, first);
      chk("slow.first_meas", first, 513);
      chk("slow.meas_cnt", meas_obs[0], 2);
      chk("slow.period", int'(bus16.period_out), 256);

      step(1'b1, 1'b0, 0, 0);
      clear_obs();
      run_sine(4 * 256 + 2, 0, 0, 2 * 256 + 50, first);
      chk("badrun.perr_cnt", perr_obs[0], 1);
      chk("badrun.meas_cnt", meas_obs[0], 3);
      chk("badrun.period", int'(bus16.period_out), 256);

      step(1'b1, 1'b0, 0, 0);
      clear_obs();
      step(1'b0, 1'b1, 0, 20);
      step(1'b0, 1'b1, 10, 0);
      ovf_at = -1;
      for (int i = 1; i <= 300; i++) begin
         step(1'b0, 1'b1, 10, 0);
         if (ovf_at < 0 && bus8.ovf) ovf_at = i;
      end
      chk("sat.ovf_at", ovf_at, 255);
      chk("sat.w8_ovf_cnt", ovf_obs[1], 1);
      chk("sat.w16_ovf_cnt", ovf_obs[0], 0);
      chk("sat.w8_meas", meas_obs[1], 0);
      step(1'b0, 1'b1, 0, 30);
      step(1'b0, 1'b1, 40, 0);
      chk("sat.rearm_no_meas", int'(bus8.meas_valid), 0);

      step(1'b1, 1'b0, 0, 0);
      run_sine(2 * 256 + 100, 0, 0, -1, first);
      step(1'b1, 1'b1, sp[100], 0);
      chk("midrst.sample", int'($signed(bus16.sample_out)), 0);
      chk("midrst.period", int'(bus16.period_out), 0);
      chk("midrst.peak", int'(bus16.peak_out), 0);
      clear_obs();
      run_sine(3 * 256, 0, 101, -1, first);
      chk("midrst.first_meas", first, 412);

      step(1'b1, 1'b0, 0, 0);
      sign = 1;
      seglen = 0;
      for (int i = 0; i < 4000; i++) begin
         if (seglen == 0) begin
            sign = -sign;
            seglen = int'($urandom_range(1, ($urandom_range(0, 9) == 0) ? 300 : 60));
         end
         seglen--;
         mag = int'($urandom_range(1, 255));
         p = (sign > 0) ? mag : 0;
         n = (sign < 0) ? mag : 0;
         r = int'($urandom_range(0, 99));
         if (r < 8) begin
            p = 0;
            n = 0;
         end else if (r < 11) begin
            p = int'($urandom_range(1, 255));
            n = int'($urandom_range(1, 255));
         end
         v = ($urandom_range(0, 3) != 0);
         if (!v) begin
            p = int'($urandom_range(0, 255));
            n = int'($urandom_range(0, 255));
         end
         rst = ($urandom_range(0, 1999) == 0);
         step(rst, v, p, n);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
